// File: rtl/pipeline_commit_checker.sv
// pipeline_commit_checker: sequences the core's reset, then checks every
// MEM/WB writeback against a preloaded FIFO of expected commits and reports
// pass / fail (first mismatch index and data) / timeout.
// Optional build macro: PIPE_CHK_X0_FILTER_EN -- writebacks to x0 are ignored.
module pipeline_commit_checker #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clear,
  output logic                       core_rst,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic [4:0]                 exp_rd,
  input  logic [XLEN-1:0]            exp_data,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(DEPTH+1)-1:0] err_index,
  output logic [XLEN-1:0]            err_data,
  output logic [31:0]                cycle_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(DEPTH+1);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } commit_t;

  state_t        state;
  commit_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] count, commit_idx;
  logic [RW-1:0] rst_cnt;

  commit_t     head;
  logic        full, empty, push, wb_elig, wb_match;
  logic [31:0] cyc_next;

  assign head      = mem[rd_ptr];
  assign full      = (count == IW'(DEPTH));
  assign empty     = (count == '0);
  assign exp_ready = (state == S_IDLE) && !full;
  assign busy      = (state == S_RESET) || (state == S_RUN);
  // clear flushes the FIFO on the same edge, so a concurrent push is dropped
  assign push      = exp_valid && exp_ready && !clear;
  assign cyc_next  = (&cycle_count) ? cycle_count : cycle_count + 32'd1;
`ifdef PIPE_CHK_X0_FILTER_EN
  assign wb_elig   = wb_valid && !empty && (wb_rd != 5'd0);
`else
  assign wb_elig   = wb_valid && !empty;
`endif
  assign wb_match  = (wb_rd == head.rd) && (wb_data == head.data);

  // FIFO storage: written on accepted pushes only, contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {exp_rd, exp_data};
  end

  // Run FSM, FIFO pointers/count and sticky status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      core_rst    <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      err_index   <= '0;
      err_data    <= '0;
      cycle_count <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      commit_idx  <= '0;
      rst_cnt     <= '0;
    end else if (clear) begin
      // flush by collapsing the read pointer onto the write pointer
      state       <= S_IDLE;
      core_rst    <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      err_index   <= '0;
      err_data    <= '0;
      cycle_count <= '0;
      rd_ptr      <= wr_ptr;
      count       <= '0;
      commit_idx  <= '0;
      rst_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + IW'(1);
          end
          if (start) begin
            state       <= S_RESET;
            core_rst    <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            err_index   <= '0;
            err_data    <= '0;
            cycle_count <= '0;
            commit_idx  <= '0;
            rst_cnt     <= '0;
          end
        end
        S_RESET: begin
          if (rst_cnt == RW'(RST_CYCLES-1)) begin
            state    <= S_RUN;
            core_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        S_RUN: begin
          cycle_count <= cyc_next;
          if (empty) begin
            // nothing was expected: pass on the first RUN edge
            state    <= S_DONE;
            core_rst <= 1'b1;
            done     <= 1'b1;
            pass     <= 1'b1;
          end else if (wb_elig && !wb_match) begin
            // decided ahead of timeout, so fail wins a tie
            state     <= S_DONE;
            core_rst  <= 1'b1;
            done      <= 1'b1;
            fail      <= 1'b1;
            err_index <= commit_idx;
            err_data  <= wb_data;
          end else if (wb_elig && count == IW'(1)) begin
            // final match also beats a simultaneous timeout
            rd_ptr     <= rd_ptr + AW'(1);
            count      <= '0;
            commit_idx <= commit_idx + IW'(1);
            state      <= S_DONE;
            core_rst   <= 1'b1;
            done       <= 1'b1;
            pass       <= 1'b1;
          end else begin
            if (wb_elig) begin
              rd_ptr     <= rd_ptr + AW'(1);
              count      <= count - IW'(1);
              commit_idx <= commit_idx + IW'(1);
            end
            if (cyc_next == 32'(TIMEOUT)) begin
              state    <= S_DONE;
              core_rst <= 1'b1;
              done     <= 1'b1;
              timeout  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          core_rst <= 1'b1;
          done     <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_commit_checker.sv
// Self-checking bench for pipeline_commit_checker: directed scenarios with
// literal expectations plus randomized runs against a queue-based model.
module tb_pipeline_commit_checker;
  localparam int XLEN       = 32;
  localparam int DEPTH      = 16;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 20;
  localparam int IW         = $clog2(DEPTH+1);
`ifdef PIPE_CHK_X0_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  localparam int P_IDLE = 0, P_RESET = 1, P_RUN = 2, P_DONE = 3;

  logic            clk = 1'b0, rst = 1'b0, start = 1'b0, clear = 1'b0;
  logic            exp_valid = 1'b0, wb_valid = 1'b0;
  logic [4:0]      exp_rd = '0, wb_rd = '0;
  logic [XLEN-1:0] exp_data = '0, wb_data = '0;
  logic            core_rst, exp_ready, busy, done, pass, fail, timeout;
  logic [IW-1:0]   err_index;
  logic [XLEN-1:0] err_data;
  logic [31:0]     cycle_count;

  always #5 clk = ~clk;

  pipeline_commit_checker #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .core_rst(core_rst),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_rd(exp_rd), .exp_data(exp_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .err_index(err_index),
    .err_data(err_data), .cycle_count(cycle_count)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            q[$];
  int              m_phase = P_IDLE, m_left = 0, m_cyc = 0, m_idx = 0, m_eidx = 0;
  logic            m_core = 1'b1, m_done = 1'b0, m_pass = 1'b0, m_fail = 1'b0, m_to = 1'b0;
  logic [XLEN-1:0] m_edata = '0;

  task automatic m_status_clear();
    m_done = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_to = 1'b0;
    m_eidx = 0; m_edata = '0; m_cyc = 0; m_idx = 0;
  endtask

  task automatic m_step();
    bit fin;
    fin = 1'b0;
    if (clear) begin
      m_phase = P_IDLE; q.delete(); m_core = 1'b1; m_status_clear();
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (exp_valid && q.size() < DEPTH) q.push_back({exp_rd, exp_data});
          if (start) begin
            m_phase = P_RESET; m_left = RST_CYCLES; m_core = 1'b1; m_status_clear();
          end
        end
        P_RESET: begin
          m_left--;
          if (m_left == 0) begin m_phase = P_RUN; m_core = 1'b0; end
        end
        P_RUN: begin
          m_cyc++;
          if (q.size() == 0) begin
            m_pass = 1'b1; fin = 1'b1;
          end else if (wb_valid && !(FILTER && wb_rd == 5'd0)) begin
            if (wb_rd == q[0].rd && wb_data == q[0].data) begin
              void'(q.pop_front());
              m_idx++;
              if (q.size() == 0) begin m_pass = 1'b1; fin = 1'b1; end
            end else begin
              m_fail = 1'b1; m_eidx = m_idx; m_edata = wb_data; fin = 1'b1;
            end
          end
          if (!fin && m_cyc == TIMEOUT) begin m_to = 1'b1; fin = 1'b1; end
          if (fin) begin m_phase = P_DONE; m_done = 1'b1; m_core = 1'b1; end
        end
        default: ;
      endcase
    end
  endtask

  // model advances on the same edges as the DUT, resets asynchronously
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_phase = P_IDLE; q.delete(); m_core = 1'b1; m_status_clear();
      end else begin
        m_step();
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_pass = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp_all();
    chk("core_rst",    64'(core_rst),    64'(m_core));
    chk("exp_ready",   64'(exp_ready),   64'(m_phase == P_IDLE && q.size() < DEPTH));
    chk("busy",        64'(busy),        64'(m_phase == P_RESET || m_phase == P_RUN));
    chk("done",        64'(done),        64'(m_done));
    chk("pass",        64'(pass),        64'(m_pass));
    chk("fail",        64'(fail),        64'(m_fail));
    chk("timeout",     64'(timeout),     64'(m_to));
    chk("err_index",   64'(err_index),   64'(m_eidx));
    chk("err_data",    64'(err_data),    64'(m_edata));
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
  endtask

  // ---------------- stimulus helpers ----------------
  ent_t st[$];
  int   k, sel, p;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [XLEN-1:0] d);
    exp_valid = 1'b1; exp_rd = rd; exp_data = d; tick(); exp_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d; tick(); wb_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (cmp_on) cmp_all();
      end
    join_none

    // reset state
    #12;
    chk("rst_core_rst",  64'(core_rst),    64'd1);
    chk("rst_busy",      64'(busy),        64'd0);
    chk("rst_done",      64'(done),        64'd0);
    chk("rst_exp_ready", 64'(exp_ready),   64'd1);
    chk("rst_cycles",    64'(cycle_count), 64'd0);
    rst = 1'b1;
    cmp_on = 1'b1;
    tick();

    // three matching commits
    push(5'd1, 32'd5); push(5'd2, 32'd7); push(5'd3, 32'hC);
    do_start();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_core_rst_hi", 64'(core_rst), 64'd1);
    tick(); tick();
    chk("t1_core_rst_lo", 64'(core_rst), 64'd0);
    wb(5'd1, 32'd5); wb(5'd2, 32'd7);
    chk("t1_run_core_rst", 64'(core_rst), 64'd0);
    chk("t1_no_done_yet", 64'(done), 64'd0);
    wb(5'd3, 32'hC);
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_err_index", 64'(err_index), 64'd0);
    chk("t1_cycles", 64'(cycle_count), 64'd3);

    // mismatch on second commit
    do_clear();
    push(5'd1, 32'd5); push(5'd2, 32'd7);
    do_start(); tick(); tick();
    wb(5'd1, 32'd5); wb(5'd2, 32'd8);
    chk("t2_fail", 64'(fail), 64'd1);
    chk("t2_pass", 64'(pass), 64'd0);
    chk("t2_err_index", 64'(err_index), 64'd1);
    chk("t2_err_data", 64'(err_data), 64'd8);
    chk("t2_core_rst", 64'(core_rst), 64'd1);

    // timeout with one pending commit
    do_clear();
    push(5'd4, 32'd1);
    do_start(); tick(); tick();
    repeat (TIMEOUT-1) tick();
    chk("t3_no_timeout_yet", 64'(timeout), 64'd0);
    tick();
    chk("t3_timeout", 64'(timeout), 64'd1);
    chk("t3_cycles", 64'(cycle_count), 64'd20);
    chk("t3_pass", 64'(pass), 64'd0);
    chk("t3_fail", 64'(fail), 64'd0);

    // x0 writeback interleaved between matching commits
    do_clear();
    push(5'd1, 32'd5); push(5'd2, 32'd7);
    do_start(); tick(); tick();
    wb(5'd1, 32'd5); wb(5'd0, 32'h99);
`ifdef PIPE_CHK_X0_FILTER_EN
    chk("t4_x0_ignored", 64'(done), 64'd0);
    wb(5'd2, 32'd7);
    chk("t4_pass", 64'(pass), 64'd1);
`else
    chk("t4_fail", 64'(fail), 64'd1);
    chk("t4_err_index", 64'(err_index), 64'd1);
    chk("t4_err_data", 64'(err_data), 64'h99);
`endif

    // full FIFO, run across pointer wrap, refill
    do_clear();
    st.delete();
    for (int i = 0; i < DEPTH; i++) begin
      ent_t e;
      e.rd = 5'($urandom_range(1, 31));
      e.data = $urandom;
      st.push_back(e);
      push(e.rd, e.data);
    end
    chk("t5_full_ready", 64'(exp_ready), 64'd0);
    push(5'd9, 32'hDEAD);
    do_start(); tick(); tick();
    for (int i = 0; i < DEPTH; i++) wb(st[i].rd, st[i].data);
    chk("t5_pass", 64'(pass), 64'd1);
    chk("t5_cycles", 64'(cycle_count), 64'd16);
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      chk("t5_refill_ready", 64'(exp_ready), 64'd1);
      push(5'(i + 1), 32'(i));
    end
    chk("t5_refull_ready", 64'(exp_ready), 64'd0);

    // async reset in the middle of a run
    do_clear();
    push(5'd1, 32'd5); push(5'd2, 32'd7);
    do_start(); tick(); tick();
    wb(5'd1, 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("t6_core_rst", 64'(core_rst), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_cycles", 64'(cycle_count), 64'd0);
    chk("t6_exp_ready", 64'(exp_ready), 64'd1);
    #4 rst = 1'b1;
    tick();

    // clear together with start stays IDLE
    push(5'd3, 32'd3);
    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    chk("t7_busy", 64'(busy), 64'd0);
    tick();
    chk("t7_still_idle", 64'(busy), 64'd0);

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      do_clear();
      st.delete();
      k = $urandom_range(0, DEPTH);
      for (int i = 0; i < k; i++) begin
        ent_t e;
        e.rd = 5'($urandom_range(0, 3));
        e.data = 32'($urandom_range(0, 3));
        st.push_back(e);
        push(e.rd, e.data);
      end
      do_start();
      p = 0;
      for (int c = 0; c < 32; c++) begin
        wb_valid = 1'b0; start = 1'b0; clear = 1'b0;
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1, 2, 3, 4, 5: if (p < st.size()) begin
            wb_valid = 1'b1; wb_rd = st[p].rd; wb_data = st[p].data; p++;
          end
          6: begin wb_valid = 1'b1; wb_rd = 5'd0; wb_data = $urandom; end
          7: begin wb_valid = 1'b1; wb_rd = 5'($urandom_range(0, 3)); wb_data = 32'($urandom_range(0, 3)); end
          8: start = 1'b1;
          default: ;
        endcase
        if ($urandom_range(0, 60) == 0) clear = 1'b1;
        tick();
      end
      wb_valid = 1'b0; start = 1'b0; clear = 1'b0;
      tick();
    end

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // hard stop so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
